// File: rtl/alu_pkg.sv
// Shared encodings for the decode-side ALU control producer and the Execute ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_ZERO = 2'b01;
  localparam logic [1:0] SRCA_PC   = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] src_a;
    logic       src_b;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Decode-to-Execute control bus; slave is the ID/EX stage, master is the pipeline around it.
interface alu_ctrl_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             stall_e;
  logic             flush_e;
  logic             valid_e;
  logic [2:0]       ALUControl_e;
  logic [1:0]       ALUSrcA_e;
  logic             ALUSrcB_e;
  logic [XLEN-1:0]  imm_e;
  logic             RegWrite_e;
  logic             MemWrite_e;
  logic [1:0]       ResultSrc_e;
  logic             Branch_e;
  logic             BranchNe_e;
  logic             Jump_e;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             illegal_e;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  instr_d, valid_d, stall_e, flush_e,
    output valid_e, ALUControl_e, ALUSrcA_e, ALUSrcB_e, imm_e, RegWrite_e,
           MemWrite_e, ResultSrc_e, Branch_e, BranchNe_e, Jump_e,
           rs1_e, rs2_e, rd_e, illegal_e, illegal_cnt
  );

  modport master (
    output instr_d, valid_d, stall_e, flush_e,
    input  valid_e, ALUControl_e, ALUSrcA_e, ALUSrcB_e, imm_e, RegWrite_e,
           MemWrite_e, ResultSrc_e, Branch_e, BranchNe_e, Jump_e,
           rs1_e, rs2_e, rd_e, illegal_e, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_stage_ctrl_decode.sv
// Combinational RV32I decode: instruction -> ALU control bundle, immediate, illegal flag.
module ctrl_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl    = '0;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: ctrl.alu_op = ALU_SLL;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b101: ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
        // 0100000 is only meaningful for sub and sra
        if (funct7 == 7'b0100000) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
        end else if (funct7 != 7'b0000000) begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_b     = 1'b1;
        imm32          = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op = ALU_SLL;
            imm32       = {27'd0, instr[24:20]};
          end
          3'b101: begin
            // shamt only, so funct7 bits never leak into the shift amount
            ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            imm32       = {27'd0, instr[24:20]};
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.src_b      = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.src_b     = 1'b1;
        ctrl.mem_write = 1'b1;
        imm32          = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        imm32       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (funct3)
          3'b000: ctrl.branch = 1'b1;
          3'b001: begin
            ctrl.branch    = 1'b1;
            ctrl.branch_ne = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.src_a      = SRCA_PC;
        ctrl.src_b      = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.reg_write  = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.src_a      = SRCA_RS1;
        ctrl.src_b      = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.reg_write  = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LUI: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.src_a     = SRCA_ZERO;
        ctrl.src_b     = 1'b1;
        ctrl.reg_write = 1'b1;
        imm32          = {instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.src_a     = SRCA_PC;
        ctrl.src_b     = 1'b1;
        ctrl.reg_write = 1'b1;
        imm32          = {instr[31:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX control register: decodes instr_d and presents the ALU control bundle to Execute.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  alu_ctrl_stage_if.slave  bus
);
  ctrl_t            dec_ctrl, ld_ctrl, ctrl_q;
  logic [XLEN-1:0]  dec_imm, ld_imm, imm_q;
  logic             dec_illegal, ld_valid, ld_illegal;
  logic [4:0]       ld_rs1, ld_rs2, ld_rd;
  logic             valid_q, illegal_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.instr_d),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Invalid or illegal instructions enter E as a fully zeroed bubble
  always_comb begin
    ld_valid   = bus.valid_d & ~dec_illegal;
    ld_illegal = bus.valid_d & dec_illegal;
    ld_ctrl    = ld_valid ? dec_ctrl : '0;
    ld_imm     = ld_valid ? dec_imm : '0;
    ld_rs1     = ld_valid ? bus.instr_d[19:15] : 5'd0;
    ld_rs2     = ld_valid ? bus.instr_d[24:20] : 5'd0;
    ld_rd      = ld_valid ? bus.instr_d[11:7] : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else if (bus.flush_e) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
    end else if (!bus.stall_e) begin
      valid_q   <= ld_valid;
      illegal_q <= ld_illegal;
      ctrl_q    <= ld_ctrl;
      imm_q     <= ld_imm;
      rs1_q     <= ld_rs1;
      rs2_q     <= ld_rs2;
      rd_q      <= ld_rd;
      if (ld_illegal && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.valid_e      = valid_q;
  assign bus.illegal_e    = illegal_q;
  assign bus.ALUControl_e = ctrl_q.alu_op;
  assign bus.ALUSrcA_e    = ctrl_q.src_a;
  assign bus.ALUSrcB_e    = ctrl_q.src_b;
  assign bus.imm_e        = imm_q;
  assign bus.RegWrite_e   = ctrl_q.reg_write;
  assign bus.MemWrite_e   = ctrl_q.mem_write;
  assign bus.ResultSrc_e  = ctrl_q.result_src;
  assign bus.Branch_e     = ctrl_q.branch;
  assign bus.BranchNe_e   = ctrl_q.branch_ne;
  assign bus.Jump_e       = ctrl_q.jump;
  assign bus.rs1_e        = rs1_q;
  assign bus.rs2_e        = rs2_q;
  assign bus.rd_e         = rd_q;
  assign bus.illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage with hand-computed expectations.
module tb_alu_ctrl_stage;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_ctrl_stage_if #(.XLEN(32), .CNT_W(8)) bus ();

  alu_ctrl_stage #(.XLEN(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_ADDI = 32'h00500013;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'hFFDFF0EF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic stl, input logic fl);
    bus.instr_d = ins;
    bus.valid_d = vld;
    bus.stall_e = stl;
    bus.flush_e = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("rst_valid", bus.valid_e, 0);
    chk("rst_alu", bus.ALUControl_e, 0);
    chk("rst_regwrite", bus.RegWrite_e, 0);
    chk("rst_cnt", bus.illegal_cnt, 0);
    rst = 1'b0;

    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    chk("add_alu", bus.ALUControl_e, 3'b000);
    chk("add_regwrite", bus.RegWrite_e, 1);
    chk("add_rd", bus.rd_e, 3);
    chk("add_rs1", bus.rs1_e, 1);
    chk("add_rs2", bus.rs2_e, 2);
    chk("add_valid", bus.valid_e, 1);
    chk("add_srcb", bus.ALUSrcB_e, 0);

    drive(I_SUB, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub_alu", bus.ALUControl_e, 3'b001);

    drive(I_SRAI, 1'b1, 1'b0, 1'b0);
    step();
    chk("srai_alu", bus.ALUControl_e, 3'b111);
    chk("srai_srcb", bus.ALUSrcB_e, 1);
    chk("srai_imm", bus.imm_e, 32'h00000003);
    chk("srai_rd", bus.rd_e, 5);

    drive(I_SLT, 1'b1, 1'b0, 1'b0);
    step();
    chk("slt_illegal", bus.illegal_e, 1);
    chk("slt_valid", bus.valid_e, 0);
    chk("slt_regwrite", bus.RegWrite_e, 0);
    chk("slt_cnt", bus.illegal_cnt, 1);

    // slt without valid_d is only a bubble
    drive(I_SLT, 1'b0, 1'b0, 1'b0);
    step();
    chk("novalid_illegal", bus.illegal_e, 0);
    chk("novalid_valid", bus.valid_e, 0);
    chk("novalid_cnt", bus.illegal_cnt, 1);

    drive(I_SLT, 1'b1, 1'b1, 1'b0);
    step();
    chk("stall_cnt_hold", bus.illegal_cnt, 1);
    drive(I_SLT, 1'b1, 1'b0, 1'b1);
    step();
    chk("flush_cnt_hold", bus.illegal_cnt, 1);
    chk("flush_illegal", bus.illegal_e, 0);

    drive(I_SLT, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 253; i++) step();
    chk("cnt_254", bus.illegal_cnt, 8'hFE);
    step();
    chk("cnt_255", bus.illegal_cnt, 8'hFF);
    for (int i = 0; i < 46; i++) step();
    chk("cnt_sat", bus.illegal_cnt, 8'hFF);

    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_XOR, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu", bus.ALUControl_e, 3'b000);
      chk("stall_valid", bus.valid_e, 1);
      chk("stall_rd", bus.rd_e, 3);
    end
    drive(I_XOR, 1'b1, 1'b0, 1'b0);
    step();
    chk("xor_alu", bus.ALUControl_e, 3'b100);

    drive(I_ADD, 1'b1, 1'b1, 1'b1);
    step();
    chk("flushstall_valid", bus.valid_e, 0);
    chk("flushstall_regwrite", bus.RegWrite_e, 0);
    chk("flushstall_rd", bus.rd_e, 0);

    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rststall_valid", bus.valid_e, 0);
    chk("rststall_regwrite", bus.RegWrite_e, 0);
    chk("rststall_rd", bus.rd_e, 0);
    chk("rststall_cnt", bus.illegal_cnt, 0);

    drive(I_ADDI, 1'b1, 1'b0, 1'b0);
    step();
    chk("addi_regwrite", bus.RegWrite_e, 0);
    chk("addi_imm", bus.imm_e, 5);
    chk("addi_valid", bus.valid_e, 1);

    drive(I_BNE, 1'b1, 1'b0, 1'b0);
    step();
    chk("bne_branch", bus.Branch_e, 1);
    chk("bne_ne", bus.BranchNe_e, 1);
    chk("bne_alu", bus.ALUControl_e, 3'b001);
    chk("bne_imm", bus.imm_e, 8);
    chk("bne_regwrite", bus.RegWrite_e, 0);

    drive(I_LUI, 1'b1, 1'b0, 1'b0);
    step();
    chk("lui_imm", bus.imm_e, 32'h12345000);
    chk("lui_srca", bus.ALUSrcA_e, 2'b01);

    drive(I_JAL, 1'b1, 1'b0, 1'b0);
    step();
    chk("jal_imm", bus.imm_e, 32'hFFFFFFFC);
    chk("jal_srca", bus.ALUSrcA_e, 2'b10);
    chk("jal_res", bus.ResultSrc_e, 2'b10);
    chk("jal_jump", bus.Jump_e, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
